// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state
// encoding and the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Pure combinational difference and borrow generation.
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per
// clock, LSB first, through a single reused full_subtractor cell.
// Optional result flags (zero, ovf) are built when SERIAL_SUB_FLAGS_EN
// is defined.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] diff_sh_reg;
    logic             borrow_reg;
    logic             capture;
    logic             shift_en;
    logic             last_bit;
    logic             cell_d;
    logic             cell_bo;

    // The cell always sees the current LSBs of the shifting operands.
    full_subtractor u_cell (
        .x  (a_sh_reg[0]),
        .y  (b_sh_reg[0]),
        .bi (borrow_reg),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working registers: operands shift right, result bits enter at the MSB
    // so that after WIDTH shifts the LSB-first result sits in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg    <= '0;
            b_sh_reg    <= '0;
            diff_sh_reg <= '0;
            borrow_reg  <= 1'b0;
            cnt_reg     <= '0;
        end else if (capture) begin
            a_sh_reg    <= a;
            b_sh_reg    <= b;
            borrow_reg  <= bin;
            cnt_reg     <= '0;
        end else if (shift_en) begin
            a_sh_reg    <= a_sh_reg >> 1;
            b_sh_reg    <= b_sh_reg >> 1;
            diff_sh_reg <= {cell_d, diff_sh_reg[WIDTH-1:1]};
            borrow_reg  <= cell_bo;
            cnt_reg     <= cnt_reg + CNT_W'(1);
        end
    end

    // Result registers change only on completion; done is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            done <= (state_reg == DONE);
            if (state_reg == DONE) begin
                diff <= diff_sh_reg;
                bout <= borrow_reg;
            end
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    logic a_msb_reg;
    logic b_msb_reg;

    // Operand sign bits are kept because the shifters consume the operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
        end else if (capture) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
        end
    end

    // Flags are registered alongside diff so they describe the same result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (state_reg == DONE) begin
            zero <= (diff_sh_reg == '0);
            ovf  <= (a_msb_reg ^ b_msb_reg) & (diff_sh_reg[WIDTH-1] ^ a_msb_reg);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4). Build with
// SERIAL_SUB_FLAGS_EN defined to also exercise the zero/ovf flags.
module tb_serial_subtractor;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_FLAGS_EN
    logic         zero;
    logic         ovf;
    logic         obs_zero;
    logic         obs_ovf;
`endif

    int checks = 0;
    int passed = 0;

    // Last completed result according to the reference model.
    logic [W-1:0] prev_diff = '0;
    logic         prev_bout = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero  (zero),
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the unsigned operands.
    function automatic logic [W:0] ref_sub(input int x, input int y, input int bi);
        int t;
        int r;
        logic bo;
        t  = x - y - bi;
        r  = ((t % MOD) + MOD) % MOD;
        bo = (x < y + bi);
        return {bo, W'(r)};
    endfunction

    // Signed overflow reference: true signed result outside the W-bit range.
    function automatic logic ref_ovf(input int x, input int y, input int bi);
        int sx;
        int sy;
        int t;
        sx = (x >= MOD / 2) ? x - MOD : x;
        sy = (y >= MOD / 2) ? y - MOD : y;
        t  = sx - sy - bi;
        return (t < -(MOD / 2)) || (t > MOD / 2 - 1);
    endfunction

    // Runs one operation; reports latency in edges after the accepting
    // edge, the result, and whether busy/done/hold behaviour was correct.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                         output int lat, output logic [W-1:0] od, output logic obo,
                         output bit ctl_ok);
        lat    = -1;
        od     = '0;
        obo    = 1'b0;
        ctl_ok = 1'b1;
        @(negedge clk);
        a = x; b = y; bin = bi; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        if (busy !== 1'b1 || done !== 1'b0 || diff !== prev_diff || bout !== prev_bout)
            ctl_ok = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                od  = diff;
                obo = bout;
`ifdef SERIAL_SUB_FLAGS_EN
                obs_zero = zero;
                obs_ovf  = ovf;
`endif
                if (busy !== 1'b0) ctl_ok = 1'b0;
                break;
            end
            if (busy !== 1'(i < W)) ctl_ok = 1'b0;
            if (diff !== prev_diff || bout !== prev_bout) ctl_ok = 1'b0;
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) ctl_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b want=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b want=0", done); else passed++;
        checks++; if (diff !== '0)   $display("FAIL reset_diff got=%0d want=0", diff); else passed++;
        checks++; if (bout !== 1'b0) $display("FAIL reset_bout got=%0b want=0", bout); else passed++;
        @(negedge clk);
        rst = 1'b0;
        $display("reset: busy=%0b done=%0b diff=%0d bout=%0b", busy, done, diff, bout);
    endtask

    task automatic test_directed();
        int           ta [3] = '{7, 3, 0};
        int           tb [3] = '{3, 7, 0};
        int           tc [3] = '{0, 0, 1};
        int           td [3] = '{4, 12, 15};
        int           te [3] = '{0, 1, 1};
        int           lat;
        logic [W-1:0] od;
        logic         obo;
        bit           ok;
        for (int i = 0; i < 3; i++) begin
            do_op(W'(ta[i]), W'(tb[i]), 1'(tc[i]), lat, od, obo, ok);
            $display("directed: a=%0d b=%0d bin=%0d -> diff=%0d bout=%0b lat=%0d",
                     ta[i], tb[i], tc[i], od, obo, lat);
            checks++; if (lat != W + 1) $display("FAIL dir_latency got=%0d want=%0d", lat, W + 1); else passed++;
            checks++; if (od !== W'(td[i])) $display("FAIL dir_diff got=%0d want=%0d", od, td[i]); else passed++;
            checks++; if (obo !== 1'(te[i])) $display("FAIL dir_bout got=%0b want=%0d", obo, te[i]); else passed++;
            checks++; if (!ok) $display("FAIL dir_control got=bad want=busy/done/hold ok"); else passed++;
            prev_diff = W'(td[i]);
            prev_bout = 1'(te[i]);
        end
    endtask

    task automatic test_ignore_start();
        int           ndone = 0;
        logic [W-1:0] od = '0;
        logic         obo = 1'b0;
        @(negedge clk);
        a = 4'd10; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                od  = diff;
                obo = bout;
            end
            if (i == 1) begin
                a = 4'd1; b = 4'd2; bin = 1'b1; start = 1'b1;
            end
            if (i == 2) start = 1'b0;
        end
        $display("ignore_start: dones=%0d diff=%0d bout=%0b", ndone, od, obo);
        checks++; if (ndone != 1) $display("FAIL ign_done_count got=%0d want=1", ndone); else passed++;
        checks++; if (od !== 4'd7) $display("FAIL ign_diff got=%0d want=7", od); else passed++;
        checks++; if (obo !== 1'b0) $display("FAIL ign_bout got=%0b want=0", obo); else passed++;
        prev_diff = 4'd7;
        prev_bout = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        int           ndone = 0;
        int           lat;
        logic [W-1:0] od;
        logic         obo;
        bit           ok;
        @(negedge clk);
        a = 4'd13; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%0b want=0", busy); else passed++;
        checks++; if (diff !== '0)   $display("FAIL rmid_diff got=%0d want=0", diff); else passed++;
        checks++; if (bout !== 1'b0) $display("FAIL rmid_bout got=%0b want=0", bout); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL rmid_done got=%0b want=0", done); else passed++;
        #1;
        rst = 1'b0;
        prev_diff = '0;
        prev_bout = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) $display("FAIL rmid_no_done got=%0d want=0", ndone); else passed++;
        do_op(4'd9, 4'd4, 1'b0, lat, od, obo, ok);
        $display("reset_mid_shift: post-reset a=9 b=4 -> diff=%0d bout=%0b lat=%0d", od, obo, lat);
        checks++; if (od !== 4'd5) $display("FAIL rmid_new_diff got=%0d want=5", od); else passed++;
        checks++; if (lat != W + 1) $display("FAIL rmid_new_latency got=%0d want=%0d", lat, W + 1); else passed++;
        checks++; if (!ok) $display("FAIL rmid_new_control got=bad want=busy/done/hold ok"); else passed++;
        prev_diff = 4'd5;
        prev_bout = 1'b0;
    endtask

    task automatic test_operand_change();
        logic [W-1:0] od = '0;
        logic         obo = 1'b1;
        bit           seen = 1'b0;
        @(negedge clk);
        a = 4'd6; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 4'd0; b = 4'd15; bin = 1'b1;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                od   = diff;
                obo  = bout;
            end
        end
        $display("operand_change: diff=%0d bout=%0b seen=%0b", od, obo, seen);
        checks++; if (!seen) $display("FAIL opchg_timeout got=no done want=done"); else passed++;
        checks++; if (od !== 4'd4) $display("FAIL opchg_diff got=%0d want=4", od); else passed++;
        checks++; if (obo !== 1'b0) $display("FAIL opchg_bout got=%0b want=0", obo); else passed++;
        prev_diff = 4'd4;
        prev_bout = 1'b0;
    endtask

    task automatic test_random();
        int           lat;
        logic [W-1:0] od;
        logic         obo;
        bit           ok;
        logic [W:0]   exp;
        int           x;
        int           y;
        int           bi;
        for (int n = 0; n < 24; n++) begin
            x   = int'($urandom_range(MOD - 1, 0));
            y   = int'($urandom_range(MOD - 1, 0));
            bi  = int'($urandom_range(1, 0));
            exp = ref_sub(x, y, bi);
            do_op(W'(x), W'(y), 1'(bi), lat, od, obo, ok);
            $display("random: a=%0d b=%0d bin=%0d -> diff=%0d bout=%0b (exp %0d/%0b) lat=%0d",
                     x, y, bi, od, obo, exp[W-1:0], exp[W], lat);
            checks++; if (od !== exp[W-1:0]) $display("FAIL rnd_diff got=%0d want=%0d", od, exp[W-1:0]); else passed++;
            checks++; if (obo !== exp[W]) $display("FAIL rnd_bout got=%0b want=%0b", obo, exp[W]); else passed++;
            checks++; if (lat != W + 1) $display("FAIL rnd_latency got=%0d want=%0d", lat, W + 1); else passed++;
            checks++; if (!ok) $display("FAIL rnd_control got=bad want=busy/done/hold ok"); else passed++;
`ifdef SERIAL_SUB_FLAGS_EN
            if (bi == 0) begin
                checks++; if (obs_ovf !== ref_ovf(x, y, 0)) $display("FAIL rnd_ovf got=%0b want=%0b", obs_ovf, ref_ovf(x, y, 0)); else passed++;
            end
            checks++; if (obs_zero !== (exp[W-1:0] == '0)) $display("FAIL rnd_zero got=%0b want=%0b", obs_zero, (exp[W-1:0] == '0)); else passed++;
`endif
            prev_diff = exp[W-1:0];
            prev_bout = exp[W];
        end
    endtask

    // start held high: each operation restarts on the edge after done.
    task automatic test_back_to_back();
        int exp_pos [4] = '{5, 11, 17, 23};
        int pos [4]     = '{-1, -1, -1, -1};
        int ndone = 0;
        int nbad  = 0;
        @(negedge clk);
        a = 4'd11; b = 4'd6; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (ndone < 4) pos[ndone] = i;
                ndone++;
                if (diff !== 4'd4 || bout !== 1'b0) nbad++;
            end
            if (i == 19) start = 1'b0;
        end
        $display("back_to_back: dones=%0d at %0d,%0d,%0d,%0d bad=%0d",
                 ndone, pos[0], pos[1], pos[2], pos[3], nbad);
        checks++; if (ndone != 4) $display("FAIL b2b_count got=%0d want=4", ndone); else passed++;
        checks++; if (nbad != 0) $display("FAIL b2b_result got=%0d bad want=0 bad", nbad); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (pos[i] != exp_pos[i]) $display("FAIL b2b_timing got=%0d want=%0d", pos[i], exp_pos[i]); else passed++;
        end
        prev_diff = 4'd4;
        prev_bout = 1'b0;
    endtask

`ifdef SERIAL_SUB_FLAGS_EN
    task automatic test_flags();
        int           lat;
        logic [W-1:0] od;
        logic         obo;
        bit           ok;
        do_op(4'd8, 4'd1, 1'b0, lat, od, obo, ok);
        $display("flags: a=8 b=1 -> diff=%0d zero=%0b ovf=%0b", od, obs_zero, obs_ovf);
        checks++; if (od !== 4'd7) $display("FAIL flg_diff1 got=%0d want=7", od); else passed++;
        checks++; if (obs_ovf !== 1'b1) $display("FAIL flg_ovf1 got=%0b want=1", obs_ovf); else passed++;
        checks++; if (obs_zero !== 1'b0) $display("FAIL flg_zero1 got=%0b want=0", obs_zero); else passed++;
        prev_diff = 4'd7;
        prev_bout = 1'b0;
        do_op(4'd5, 4'd5, 1'b0, lat, od, obo, ok);
        $display("flags: a=5 b=5 -> diff=%0d zero=%0b ovf=%0b", od, obs_zero, obs_ovf);
        checks++; if (od !== 4'd0) $display("FAIL flg_diff2 got=%0d want=0", od); else passed++;
        checks++; if (obs_zero !== 1'b1) $display("FAIL flg_zero2 got=%0b want=1", obs_zero); else passed++;
        checks++; if (obs_ovf !== 1'b0) $display("FAIL flg_ovf2 got=%0b want=0", obs_ovf); else passed++;
        prev_diff = 4'd0;
        prev_bout = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_shift();
        test_operand_change();
        test_random();
        test_back_to_back();
`ifdef SERIAL_SUB_FLAGS_EN
        test_flags();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepted start.
REQ-007 bin  input  1  borrow-in; captured on the accepted start.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse marking diff/bout valid.
REQ-010 diff  output  WIDTH  registered result, a - b - bin mod 2^WIDTH.
REQ-011 bout  output  1  registered borrow-out; 1 when a < b + bin, unsigned.
REQ-012 zero, ovf  output  1 each  result flags; these ports exist only under the configuration macro (REQ-026).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 IDLE -> SHIFT on start=1: capture a, b, bin; clear the bit counter; busy=1 from the next cycle.
REQ-015 In SHIFT, one bit per cycle, LSB first: diff bit i = a_i ^ b_i ^ borrow; borrow updated from a_i, b_i and borrow, starting from the captured bin.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, then transition to DONE.
REQ-017 In DONE: load diff and bout from the working registers; done=1 and busy=0 for exactly one cycle; then go to IDLE.
REQ-018 Latency: a start accepted at edge k SHALL produce done=1 in the cycle following edge k+WIDTH+1.
REQ-019 diff and bout SHALL hold their last completed values, unchanged during SHIFT, until the next DONE.
REQ-020 start in SHIFT or DONE SHALL be ignored; no queuing.
REQ-021 Operand changes after capture SHALL NOT affect the result in progress.
REQ-022 Wrap-around: a negative true difference SHALL yield its two's-complement residue mod 2^WIDTH, with bout=1.

Reset
REQ-023 On rst=1, asynchronously: state=IDLE; busy=0, done=0, diff=0, bout=0 (and zero=0, ovf=0 when present).
REQ-024 Reset mid-SHIFT SHALL abort the operation; no done pulse SHALL follow.
REQ-025 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-026 Macro SERIAL_SUB_FLAGS_EN, when defined: ports zero and ovf exist and are updated in DONE.
  - zero = 1 when diff == 0.
  - ovf = 1 on signed two's-complement overflow: operand MSBs differ and the diff MSB differs from the a MSB.
REQ-027 When SERIAL_SUB_FLAGS_EN is undefined: neither port nor its logic exists; all other behaviour is identical.

Structure
REQ-028 Shared package serial_subtractor_pkg SHALL hold:
  - the state enumeration typedef (IDLE, SHIFT, DONE);
  - the default WIDTH constant.
REQ-029 The 1-bit cell SHALL be sub-module full_subtractor, instantiated once and reused each SHIFT cycle.
  - Inputs: x, y, bi. Outputs: d, bo.
  - d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
REQ-030 The bit counter SHALL be clog2(WIDTH+1) bits wide.

Verification (WIDTH=4)
REQ-031 a=7, b=3, bin=0 -> done after 5 edges; diff=4, bout=0.
REQ-032 a=3, b=7, bin=0 -> diff=12, bout=1; a=0, b=0, bin=1 -> diff=15, bout=1.
REQ-033 Second start pulsed 2 cycles after the first -> ignored; exactly one done; the result matches the first operands.
REQ-034 rst pulsed during cycle 2 of SHIFT:
  - all outputs 0 immediately; no done follows;
  - a new start (a=9, b=4) then gives diff=5.
REQ-035 With SERIAL_SUB_FLAGS_EN: a=8, b=1, bin=0 -> diff=7, ovf=1, zero=0; a=5, b=5 -> diff=0, zero=1, ovf=0.
REQ-036 a changed to 0 during SHIFT of a=6, b=2 -> diff=4 (captured operand used).
